udp_tx_sched: RTL

UDP_TX_SCHED -- requirements
Module: udp_tx_sched

---
 rtl/udp_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/udp_tx_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/udp_pkg.sv
// udp_pkg -- shared definitions for the UDP transmit scheduler.
//   state_t          : scheduler FSM encoding
//   UDP_HDR_LEN      : UDP header bytes added to the payload length
//   IP_HDR_LEN       : IPv4 header bytes added on top of the UDP length
//   MAX_PAYLOAD      : largest payload that fits one Ethernet frame
//   DEFAULT_SRC_PORT : fixed UDP source port
//   len_valid()      : payload length acceptance rule
package udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_EN = 3'd3,
    ST_BUSY    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  localparam logic [15:0] UDP_HDR_LEN      = 16'd8;
  localparam logic [15:0] IP_HDR_LEN       = 16'd20;
  localparam logic [15:0] MAX_PAYLOAD      = 16'd1472;
  localparam logic [15:0] DEFAULT_SRC_PORT = 16'd8080;

  // A payload is sendable when non-empty, word aligned and within one frame.
  function automatic logic len_valid(input logic [15:0] len);
    return (len != 16'd0) && (len[1:0] == 2'b00) && (len <= MAX_PAYLOAD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin picker.
//   req   : request vector, one bit per channel
//   ptr   : highest-priority channel index for this pick
//   grant : one-hot winner (all zero when no request)
// The first requester at or above ptr wins; if none, the lowest requester wins
// (wrap-around).
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         grant
);

  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  logic [NUM_CH-1:0] upper;
  logic [NUM_CH-1:0] upper_first;
  logic [NUM_CH-1:0] any_first;

  // Isolate lowest set bit with x & -x, first among channels >= ptr, else overall.
  always_comb begin
    upper       = req & ({NUM_CH{1'b1}} << ptr);
    upper_first = upper & (~upper + ONE);
    any_first   = req & (~req + ONE);
    if (upper != {NUM_CH{1'b0}}) begin
      grant = upper_first;
    end else begin
      grant = any_first;
    end
  end

endmodule

// File: rtl/udp_tx_sched.sv
// udp_tx_sched -- shares one UDP transmitter among NUM_CH requesting channels.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ch_req              : per-channel frame request (level, held until grant)
//   ch_len/ch_dst_port  : per-channel payload byte count / destination port (16b each)
//   ch_data             : per-channel payload word (32b each)
//   ch_grant            : one-hot owner, set from tx_start until tx_en falls
//   ch_data_req         : tx_data_req forwarded to the owner only
//   ch_err              : one-cycle pulse on rejected length or watchdog abort
//   tx_start            : one-cycle frame start to the transmitter
//   tx_data_length      : UDP length (payload + 8)
//   tx_total_length     : IP total length (payload + 28)
//   src_port / dst_port : UDP ports (src fixed at 8080)
//   tx_datain           : owner's payload word (0 when nobody owns the transmitter)
//   tx_data_req, tx_en  : transmitter word request / frame active
// Optional build macro UDP_TX_SCHED_WDOG_EN: adds a frame watchdog that aborts a
// frame after WDOG_CYCLES cycles counted from tx_start.
module udp_tx_sched
  import udp_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int IFG_CYCLES  = 12,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [16*NUM_CH-1:0]   ch_len,
  input  logic [16*NUM_CH-1:0]   ch_dst_port,
  input  logic [32*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]      ch_grant,
  output logic [NUM_CH-1:0]      ch_data_req,
  output logic [NUM_CH-1:0]      ch_err,
  output logic                   tx_start,
  output logic [15:0]            tx_data_length,
  output logic [15:0]            tx_total_length,
  output logic [15:0]            src_port,
  output logic [15:0]            dst_port,
  output logic [31:0]            tx_datain,
  input  logic                   tx_data_req,
  input  logic                   tx_en
);

  localparam int PW = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("udp_tx_sched: NUM_CH must be 2..8");
  end
  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("udp_tx_sched: WDOG_CYCLES must be at least 2");
  end

  state_t              state;
  state_t              state_n;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       ptr_n;
  logic [PW-1:0]       owner;
  logic [PW-1:0]       owner_n;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       ptr_after_win;
  logic [NUM_CH-1:0]   win;
  logic [NUM_CH-1:0]   grant_n;
  logic [NUM_CH-1:0]   err_n;
  logic                tx_start_n;
  logic [15:0]         dlen_n;
  logic [15:0]         tlen_n;
  logic [15:0]         dport_n;
  logic [15:0]         gap_cnt;
  logic [15:0]         gap_cnt_n;
  logic                wdog_expired;

  logic [15:0] len_arr   [NUM_CH];
  logic [15:0] dport_arr [NUM_CH];
  logic [31:0] data_arr  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign len_arr[g]   = ch_len[16*g +: 16];
    assign dport_arr[g] = ch_dst_port[16*g +: 16];
    assign data_arr[g]  = ch_data[32*g +: 32];
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req   (ch_req),
    .ptr   (ptr),
    .grant (win)
  );

  // One-hot winner to index; OR-accumulate keeps the loop free of a hold branch.
  always_comb begin
    win_idx = {PW{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      win_idx = win_idx | (win[i] ? PW'(i) : {PW{1'b0}});
    end
  end

  assign ptr_after_win = (win_idx == PW'(NUM_CH - 1)) ? {PW{1'b0}} : (win_idx + PW'(1));

`ifdef UDP_TX_SCHED_WDOG_EN
  logic [31:0] wdog_cnt;

  // Cycles since tx_start: START counts as 1, WAIT_EN/BUSY keep counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= 32'd0;
    end else if (state == ST_START) begin
      wdog_cnt <= 32'd1;
    end else if (state == ST_WAIT_EN || state == ST_BUSY) begin
      wdog_cnt <= wdog_cnt + 32'd1;
    end else begin
      wdog_cnt <= 32'd0;
    end
  end

  assign wdog_expired = (state == ST_WAIT_EN || state == ST_BUSY) &&
                        (wdog_cnt >= 32'(WDOG_CYCLES - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  // Next-state and next registered-output values.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    grant_n    = ch_grant;
    err_n      = {NUM_CH{1'b0}};
    tx_start_n = 1'b0;
    dlen_n     = tx_data_length;
    tlen_n     = tx_total_length;
    dport_n    = dst_port;
    gap_cnt_n  = 16'd0;
    case (state)
      ST_IDLE: begin
        if ((ch_req != {NUM_CH{1'b0}}) && !tx_en) begin
          state_n = ST_ARB;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ARB: begin
        // The request may have been withdrawn since IDLE; then nothing happens.
        if (win == {NUM_CH{1'b0}}) begin
          state_n = ST_IDLE;
        end else if (len_valid(len_arr[win_idx])) begin
          owner_n    = win_idx;
          grant_n    = win;
          tx_start_n = 1'b1;
          dlen_n     = len_arr[win_idx] + UDP_HDR_LEN;
          tlen_n     = len_arr[win_idx] + UDP_HDR_LEN + IP_HDR_LEN;
          dport_n    = dport_arr[win_idx];
          ptr_n      = ptr_after_win;
          state_n    = ST_START;
        end else begin
          err_n   = win;
          ptr_n   = ptr_after_win;
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        state_n = ST_WAIT_EN;
      end
      ST_WAIT_EN: begin
        if (wdog_expired) begin
          err_n   = ch_grant;
          grant_n = {NUM_CH{1'b0}};
          state_n = ST_GAP;
        end else if (tx_en) begin
          state_n = ST_BUSY;
        end else begin
          state_n = ST_WAIT_EN;
        end
      end
      ST_BUSY: begin
        if (wdog_expired) begin
          err_n   = ch_grant;
          grant_n = {NUM_CH{1'b0}};
          state_n = ST_GAP;
        end else if (!tx_en) begin
          grant_n = {NUM_CH{1'b0}};
          state_n = ST_GAP;
        end else begin
          state_n = ST_BUSY;
        end
      end
      ST_GAP: begin
        if ((gap_cnt + 16'd1) >= 16'(IFG_CYCLES)) begin
          state_n = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 16'd1;
          state_n   = ST_GAP;
        end
      end
      default: begin
        grant_n = {NUM_CH{1'b0}};
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      ptr             <= {PW{1'b0}};
      owner           <= {PW{1'b0}};
      ch_grant        <= {NUM_CH{1'b0}};
      ch_err          <= {NUM_CH{1'b0}};
      tx_start        <= 1'b0;
      tx_data_length  <= 16'd0;
      tx_total_length <= 16'd0;
      dst_port        <= 16'd0;
      gap_cnt         <= 16'd0;
    end else begin
      state           <= state_n;
      ptr             <= ptr_n;
      owner           <= owner_n;
      ch_grant        <= grant_n;
      ch_err          <= err_n;
      tx_start        <= tx_start_n;
      tx_data_length  <= dlen_n;
      tx_total_length <= tlen_n;
      dst_port        <= dport_n;
      gap_cnt         <= gap_cnt_n;
    end
  end

  // Grant is one-hot on the owner, so gating by it routes the request to the owner only.
  assign ch_data_req = tx_data_req ? ch_grant : {NUM_CH{1'b0}};
  assign tx_datain   = (ch_grant != {NUM_CH{1'b0}}) ? data_arr[owner] : 32'd0;
  assign src_port    = DEFAULT_SRC_PORT;

endmodule
